s_bits_sequencer: RTL and testbench

//  Driver side of the start/s_bits handshake. On a start pulse it steps s_bits

---
 rtl/s_bits_sequencer.sv | 108 ++++++++++
 tb/tb_s_bits_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/s_bits_sequencer.sv
// Start/s_bits handshake driver: steps IDLE -> STATE1 -> STATE2 -> optional STATE3 hold -> IDLE,
// and tracks completed sequences and restarts.
module s_bits_sequencer #(
    parameter int HOLD_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [HOLD_W-1:0] hold_cycles,
    output logic [1:0]        s_bits,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  seq_count,
    output logic [CNT_W-1:0]  restarts
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        STATE1 = 2'b01,
        STATE2 = 2'b10,
        STATE3 = 2'b11
    } state_e;

    state_e             state_q, state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   seq_count_q, seq_count_d;
    logic [CNT_W-1:0]   restarts_q, restarts_d;
    logic               complete;
    logic               restart;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            done_q      <= 1'b0;
            seq_count_q <= '0;
            restarts_q  <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            done_q      <= done_d;
            seq_count_q <= seq_count_d;
            restarts_q  <= restarts_d;
        end
    end

    // start outranks abort everywhere; abort only matters once past STATE1.
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        complete = 1'b0;
        restart  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = STATE1;
            end
            STATE1: begin
                if (start) restart = 1'b1;
                else       state_d = STATE2;
            end
            STATE2: begin
                if (start) begin
                    state_d = STATE1;
                    restart = 1'b1;
                end else if (abort) begin
                    state_d = IDLE;
                end else if (hold_cycles == '0) begin
                    state_d  = IDLE;
                    complete = 1'b1;
                end else begin
                    state_d = STATE3;
                    hold_d  = hold_cycles - HOLD_W'(1);
                end
            end
            STATE3: begin
                if (start) begin
                    state_d = STATE1;
                    restart = 1'b1;
                end else if (abort) begin
                    state_d = IDLE;
                end else if (hold_q == '0) begin
                    state_d  = IDLE;
                    complete = 1'b1;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
        endcase
    end

    // seq_count wraps naturally; restarts sticks at all-ones.
    always_comb begin
        done_d      = complete;
        seq_count_d = seq_count_q + CNT_W'(complete);
        restarts_d  = restarts_q;
        if (restart && (restarts_q != '1)) restarts_d = restarts_q + CNT_W'(1);
    end

    assign s_bits    = state_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign seq_count = seq_count_q;
    assign restarts  = restarts_q;

endmodule

// File: tb/tb_s_bits_sequencer.sv
// Directed bench for s_bits_sequencer with a small start |=> STATE1 ##1 STATE2 monitor.
module tb_s_bits_sequencer;

    localparam int HOLD_W = 4;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic [HOLD_W-1:0] hold_cycles;
    logic [1:0]        s_bits;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  seq_count;
    logic [CNT_W-1:0]  restarts;

    int n_checks = 0;
    int n_errors = 0;
    int chk_viol = 0;
    int viol_base;
    int done_seen;
    logic st1_q, st2_q;

    s_bits_sequencer #(.HOLD_W(HOLD_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .hold_cycles(hold_cycles), .s_bits(s_bits), .busy(busy), .done(done),
        .seq_count(seq_count), .restarts(restarts)
    );

    always #5 clk = ~clk;

    // Protocol monitor: a sampled start must be followed by STATE1 then STATE2.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st1_q <= 1'b0;
            st2_q <= 1'b0;
        end else begin
            st2_q <= st1_q;
            st1_q <= start;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (st1_q && s_bits != 2'b01) chk_viol++;
            if (st2_q && s_bits != 2'b10) chk_viol++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_t1(input string pfx, input logic [CNT_W-1:0] exp_seq);
        hold_cycles = 4'd3;
        pulse_start();
        check({pfx, " s@t+1"}, s_bits, 2'b01);
        check({pfx, " busy@t+1"}, busy, 1);
        @(negedge clk);
        check({pfx, " s@t+2"}, s_bits, 2'b10);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check({pfx, " s@STATE3"}, s_bits, 2'b11);
            check({pfx, " done@STATE3"}, done, 0);
        end
        @(negedge clk);
        check({pfx, " s@t+6"}, s_bits, 2'b00);
        check({pfx, " done@t+6"}, done, 1);
        check({pfx, " seq"}, seq_count, exp_seq);
        @(negedge clk);
        check({pfx, " done@t+7"}, done, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        hold_cycles = '0;
        #1;
        check("rst s_bits", s_bits, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst seq", seq_count, 0);
        check("rst restarts", restarts, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // T1
        run_t1("T1", 8'd1);

        // T2: zero hold skips STATE3
        hold_cycles = 4'd0;
        pulse_start();
        check("T2 s@t+1", s_bits, 2'b01);
        @(negedge clk);
        check("T2 s@t+2", s_bits, 2'b10);
        @(negedge clk);
        check("T2 s@t+3", s_bits, 2'b00);
        check("T2 done", done, 1);
        check("T2 seq", seq_count, 2);
        @(negedge clk);

        // T3: restart in the second STATE3 cycle
        hold_cycles = 4'd5;
        pulse_start();
        @(negedge clk);
        @(negedge clk);
        check("T3 s 1st S3", s_bits, 2'b11);
        @(negedge clk);
        check("T3 s 2nd S3", s_bits, 2'b11);
        pulse_start();
        check("T3 s restart", s_bits, 2'b01);
        check("T3 restarts", restarts, 1);
        check("T3 done", done, 0);
        check("T3 seq hold", seq_count, 2);
        @(negedge clk);
        check("T3 s S2", s_bits, 2'b10);
        done_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("T3 s S3 again", s_bits, 2'b11);
            check("T3 seq mid", seq_count, 2);
        end
        @(negedge clk);
        check("T3 s end", s_bits, 2'b00);
        check("T3 done end", done, 1);
        check("T3 seq end", seq_count, 3);
        @(negedge clk);

        // T4: abort ignored in STATE1, honoured in STATE3
        hold_cycles = 4'd3;
        pulse_start();
        abort = 1'b1;
        @(negedge clk);
        check("T4 S1 abort ignored", s_bits, 2'b10);
        abort = 1'b0;
        @(negedge clk);
        check("T4 s S3", s_bits, 2'b11);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("T4 s aborted", s_bits, 2'b00);
        check("T4 done", done, 0);
        check("T4 seq", seq_count, 3);
        @(negedge clk);
        check("T4 done after", done, 0);
        check("monitor clean", chk_viol, 0);

        // T5: asynchronous reset mid-STATE2
        pulse_start();
        @(negedge clk);
        check("T5 s S2", s_bits, 2'b10);
        #2 rst_n = 1'b0;
        #1;
        check("T5 s async", s_bits, 0);
        check("T5 busy async", busy, 0);
        check("T5 seq async", seq_count, 0);
        check("T5 restarts async", restarts, 0);
        @(negedge clk);
        rst_n = 1'b1;
        check("T5 done", done, 0);
        @(negedge clk);
        run_t1("T5", 8'd1);

        // T6: start held for 4 cycles
        viol_base = chk_viol;
        hold_cycles = 4'd0;
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("T6 s held", s_bits, 2'b01);
            check("T6 restarts", restarts, i);
        end
        start = 1'b0;
        @(negedge clk);
        check("T6 s S2", s_bits, 2'b10);
        @(negedge clk);
        check("T6 done", done, 1);
        check("T6 monitor flags", (chk_viol > viol_base), 1);

        // restarts saturation
        start = 1'b1;
        repeat (300) @(negedge clk);
        start = 1'b0;
        check("restarts sat", restarts, 8'hFF);
        repeat (3) @(negedge clk);
        check("sat s idle", s_bits, 0);

        // seq_count wrap after 2^CNT_W+1 sequences
        do_reset();
        hold_cycles = 4'd0;
        for (int i = 0; i < (1 << CNT_W) + 1; i++) begin
            pulse_start();
            @(negedge clk);
            @(negedge clk);
        end
        check("wrap done", done, 1);
        check("wrap seq", seq_count, 1);
        check("wrap restarts", restarts, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
